// File: rtl/otter_fetch_queue.sv
// Instruction-fetch front end: issues sequential fetches to a 1-cycle memory port and buffers
// {IR, PC} pairs in a small FIFO for Decode; a redirect flushes the queue and restarts fetch.
module otter_fetch_queue #(
    parameter int unsigned QUEUE_DEPTH  = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic [31:0] MEM_ADDR1,
    output logic        MEM_READ1,
    input  logic [31:0] MEM_DOUT1,
    output logic        IF_VALID,
    output logic [31:0] IF_IR,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_NEXT_PC,
    input  logic        DE_READY,
    output logic        FETCH_MISALIGN
);

    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned OccW = CntW + 1;
    localparam logic [OccW-1:0] DepthOcc = OccW'(QUEUE_DEPTH);

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     issue_pc_q, issue_pc_d;
    logic            inflight_q, inflight_d;
    logic            drop_q, drop_d;
    logic            misalign_q, misalign_d;
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     ir_q [QUEUE_DEPTH];
    logic [31:0]     ir_d [QUEUE_DEPTH];
    logic [31:0]     pc_q [QUEUE_DEPTH];
    logic [31:0]     pc_d [QUEUE_DEPTH];

    logic            pop;
    logic            push;
    logic            issue;
    logic [OccW-1:0] occ;

    always_comb begin
        IF_VALID   = (count_q != '0) & ~REDIRECT & ~RESET;
        IF_IR      = ir_q[head_q];
        IF_PC      = pc_q[head_q];
        IF_NEXT_PC = pc_q[head_q] + 32'd4;
        pop        = IF_VALID & DE_READY;
        push       = inflight_q & ~drop_q & ~REDIRECT & ~RESET;
        // Credit check: queued + inflight words after this cycle's pop must fit the queue.
        occ        = OccW'(count_q) + OccW'(inflight_q) - OccW'(pop);
        issue      = ~RESET & ~REDIRECT & (occ < DepthOcc);
        MEM_ADDR1  = fetch_pc_q;
        MEM_READ1  = issue;
        FETCH_MISALIGN = misalign_q;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        issue_pc_d = issue_pc_q;
        inflight_d = issue;
        drop_d     = drop_q;
        misalign_d = REDIRECT & ~RESET & (REDIRECT_PC[1:0] != 2'b00);
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        ir_d       = ir_q;
        pc_d       = pc_q;

        if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            issue_pc_d = fetch_pc_q;
        end
        if (push) begin
            ir_d[tail_q] = MEM_DOUT1;
            pc_d[tail_q] = issue_pc_q;
            tail_d       = tail_q + PtrW'(1);
        end
        if (pop) begin
            head_d = head_q + PtrW'(1);
        end
        count_d = count_q + CntW'(push) - CntW'(pop);

        if (RESET) begin
            fetch_pc_d = RESET_VECTOR;
            inflight_d = 1'b0;
            drop_d     = 1'b0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else if (REDIRECT) begin
            fetch_pc_d = {REDIRECT_PC[31:2], 2'b00};
            drop_d     = 1'b0;
            head_d     = tail_q;
            count_d    = '0;
        end
    end

    always_ff @(posedge CLK) begin
        fetch_pc_q <= fetch_pc_d;
        issue_pc_q <= issue_pc_d;
        inflight_q <= inflight_d;
        drop_q     <= drop_d;
        misalign_q <= misalign_d;
        head_q     <= head_d;
        tail_q     <= tail_d;
        count_q    <= count_d;
    end

    // Storage needs no reset; only entries below count are ever presented as valid.
    always_ff @(posedge CLK) begin
        ir_q <= ir_d;
        pc_q <= pc_d;
    end

endmodule
